// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared encodings and terminal counts for universal_counter4
package counter_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic MODE_BIN = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic [CNT_W-1:0] BIN_MAX = 4'd15;
  localparam logic [CNT_W-1:0] DEC_TOP = 4'd9;

endpackage

// File: rtl/counter_next.sv
// rtl/counter_next.sv - combinational next-value function with explicit wrap
module counter_next
  import counter_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEC_MAX = DEC_TOP
) (
  input  logic [CNT_W-1:0] cur,
  input  logic             mode,
  input  logic             incr,
  output logic [CNT_W-1:0] nxt
);

  logic [CNT_W-1:0] top;

  always_comb begin
    top = (mode == MODE_DEC) ? DEC_MAX : BIN_MAX;
    nxt = cur;
    if (incr == DIR_UP) begin
      // >= also folds an out-of-range decade value back to zero
      if (cur >= top) nxt = '0;
      else            nxt = cur + 4'd1;
    end else begin
      if (cur == '0)       nxt = top;
      else if (cur > top)  nxt = top;
      else                 nxt = cur - 4'd1;
    end
  end

endmodule

// File: rtl/universal_counter4.sv
// rtl/universal_counter4.sv - 4-bit binary/decade up/down counter with clear and pause
module universal_counter4
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DEC_MAX = 9
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             mode,
  input  logic             incr,
  input  logic             pause,
  output logic [WIDTH-1:0] count
);

  logic [CNT_W-1:0] nxt;

  counter_next #(
    .DEC_MAX (CNT_W'(DEC_MAX))
  ) u_next (
    .cur  (count),
    .mode (mode),
    .incr (incr),
    .nxt  (nxt)
  );

  // clear beats pause, pause beats counting
  always_ff @(posedge clk) begin
    if (clear)       count <= '0;
    else if (!pause) count <= nxt;
  end

endmodule

// File: tb/tb_universal_counter4.sv
// tb/tb_universal_counter4.sv - scoreboard bench for universal_counter4
module tb_universal_counter4;

  logic       clk = 1'b0;
  logic       clear, mode, incr, pause;
  logic [3:0] count;

  typedef struct {
    int         id;
    logic [3:0] exp;
  } item_t;

  item_t exp_q[$];
  bit    done = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    vec_id = 0;

  universal_counter4 #(.WIDTH(4), .DEC_MAX(9)) dut (
    .clk   (clk),
    .clear (clear),
    .mode  (mode),
    .incr  (incr),
    .pause (pause),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic c, input logic m, input logic i,
                      input logic p, input logic [3:0] e);
    item_t it;
    @(negedge clk);
    clear = c; mode = m; incr = i; pause = p;
    @(posedge clk);
    it.id  = vec_id;
    it.exp = e;
    vec_id++;
    exp_q.push_back(it);
  endtask

  task automatic up_bin(input int n);
    for (int k = 1; k <= n; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'(k));
  endtask

  initial begin
    clear = 1'b0; mode = 1'b0; incr = 1'b1; pause = 1'b0;

    // 1: clear then binary up
    step(1,0,1,0, 0); step(1,0,1,0, 0);
    up_bin(6);

    // 2: pause hold, then down through zero
    step(0,0,1,1, 6); step(0,0,1,1, 6); step(0,0,1,1, 6);
    step(0,0,0,0, 5); step(0,0,0,0, 4); step(0,0,0,0, 3);
    step(0,0,0,0, 2); step(0,0,0,0, 1); step(0,0,0,0, 0);
    step(0,0,0,0, 15);

    // 3: binary up wrap and clear mid-count
    step(0,0,0,0, 14);
    step(0,0,1,0, 15); step(0,0,1,0, 0); step(0,0,1,0, 1);
    step(1,0,1,0, 0);

    // 4: decade up/down and wrap 9->0
    step(1,1,1,0, 0);
    step(0,1,1,0, 1); step(0,1,1,0, 2); step(0,1,1,0, 3);
    step(0,1,1,0, 4); step(0,1,1,0, 5); step(0,1,1,0, 6);
    step(0,1,0,0, 5); step(0,1,0,0, 4);
    step(0,1,1,0, 5); step(0,1,1,0, 6); step(0,1,1,0, 7);
    step(0,1,1,0, 8); step(0,1,1,0, 9); step(0,1,1,0, 0);
    step(0,1,1,0, 1); step(0,1,1,0, 2); step(0,1,1,0, 3);
    step(0,1,1,0, 4); step(0,1,1,0, 5); step(0,1,1,0, 6);
    step(0,1,1,0, 7); step(0,1,1,0, 8);

    // 5: decade down wrap 0->9, out-of-range recovery
    step(1,1,0,0, 0);
    step(0,1,0,0, 9);
    step(1,0,1,0, 0);
    up_bin(13);
    step(0,1,1,0, 0);
    step(1,0,1,0, 0);
    up_bin(13);
    step(0,1,0,0, 9);
    step(0,1,0,0, 8);

    // 6: clear beats pause, pause ignores mode/incr toggling
    step(1,0,1,1, 0);
    up_bin(3);
    step(0,1,0,1, 3); step(0,0,1,1, 3); step(0,1,1,1, 3); step(0,0,0,1, 3);
    step(0,0,1,0, 4);

    done = 1'b1;
  end

  initial begin : monitor
    item_t it;
    int    idle;
    idle = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        checks++;
        if (count !== it.exp) begin
          errors++;
          $display("FAIL vec%0d count=%0d expected=%0d", it.id, count, it.exp);
        end
      end
      if (done && exp_q.size() == 0) break;
      idle++;
      if (idle > 2000) begin
        errors++;
        $display("FAIL timeout pending=%0d expected=0", exp_q.size());
        break;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
